// File: rtl/sdram16_bram_responder.sv
// sdram16_bram_responder: stands in for the SDRAM controller behind mem_shim.
// An on-chip 16-bit word array answers each request after a programmable
// access latency. Periodic refresh windows stall the bus through busy.
module sdram16_bram_responder #(
  parameter int ADDR_W         = 10,
  parameter int LATENCY        = 4,
  parameter int REFRESH_PERIOD = 256,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [24:0] sdram_addr_i,
  input  logic        sdram_rd_i,
  input  logic        sdram_wr_i,
  input  logic [15:0] sdram_din_i,
  output logic [15:0] sdram_dout_o,
  output logic        sdram_ack_o,
  output logic        sdram_busy_o,
  output logic        proto_err_o
);

  localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [RW-1:0] RFSH_LAST = RW'((REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0);
  localparam logic [3:0]    LAT_LAST  = 4'(LATENCY);
  localparam logic [3:0]    LAT_PRE   = 4'(LATENCY - 1);
  localparam logic [7:0]    LEN_LAST  = 8'(REFRESH_CYCLES);

  typedef enum logic [1:0] {IDLE, ACCESS, REFRESH} state_e;

  state_e            state_q, state_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic [7:0]        rfsh_len_q, rfsh_len_d;
  logic [RW-1:0]     rfsh_cnt_q, rfsh_cnt_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [15:0]       data_q, data_d;
  logic              is_wr_q, is_wr_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [15:0]       dout_q, dout_d;
  logic              perr_q, perr_d;
  logic              mem_we;
  logic              strobe, accept, wrap;

  logic [15:0] mem_q [2**ADDR_W];

  // Byte-address bit 0 and everything above the array index alias away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{sdram_addr_i[24:ADDR_W+1], sdram_addr_i[0]};

  // Next-state logic: request acceptance, latency countdown, refresh scheduling.
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    rfsh_len_d = rfsh_len_q;
    rfsh_cnt_d = rfsh_cnt_q;
    pending_d  = pending_q;
    idx_d      = idx_q;
    data_d     = data_q;
    is_wr_d    = is_wr_q;
    dout_d     = dout_q;
    perr_d     = perr_q;
    ack_d      = 1'b0;
    mem_we     = 1'b0;

    strobe = sdram_rd_i | sdram_wr_i;
    accept = strobe & ~busy_q;
    wrap   = (REFRESH_PERIOD != 0) && (rfsh_cnt_q == RFSH_LAST);

    if (REFRESH_PERIOD == 0)
      rfsh_cnt_d = '0;
    else if (wrap)
      rfsh_cnt_d = '0;
    else
      rfsh_cnt_d = rfsh_cnt_q + 1'b1;

    if ((strobe && busy_q) || (sdram_rd_i && sdram_wr_i))
      perr_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = ACCESS;
          lat_cnt_d = 4'd1;
          idx_d     = sdram_addr_i[ADDR_W:1];
          data_d    = sdram_din_i;
          is_wr_d   = sdram_wr_i;
        end else if (pending_q) begin
          state_d    = REFRESH;
          pending_d  = 1'b0;
          rfsh_len_d = 8'd1;
        end
      end
      ACCESS: begin
        if (lat_cnt_q == LAT_LAST) begin
          if (pending_q) begin
            state_d    = REFRESH;
            pending_d  = 1'b0;
            rfsh_len_d = 8'd1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
          if (lat_cnt_q == LAT_PRE) begin
            ack_d = 1'b1;
            if (is_wr_q)
              mem_we = 1'b1;
            else
              dout_d = mem_q[idx_q];
          end
        end
      end
      REFRESH: begin
        if (rfsh_len_q == LEN_LAST)
          state_d = IDLE;
        else
          rfsh_len_d = rfsh_len_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase

    if (wrap)
      pending_d = 1'b1;

    busy_d = (state_d != IDLE) | pending_d;
  end

  // Control and output registers; the array itself is not touched by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      lat_cnt_q  <= 4'd0;
      rfsh_len_q <= 8'd0;
      rfsh_cnt_q <= '0;
      pending_q  <= 1'b0;
      idx_q      <= '0;
      data_q     <= 16'd0;
      is_wr_q    <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      dout_q     <= 16'd0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      rfsh_len_q <= rfsh_len_d;
      rfsh_cnt_q <= rfsh_cnt_d;
      pending_q  <= pending_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      is_wr_q    <= is_wr_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      dout_q     <= dout_d;
      perr_q     <= perr_d;
    end
  end

  // Word array write port, committed on the edge that raises ack.
  always_ff @(posedge clk_i) begin
    if (mem_we)
      mem_q[idx_q] <= data_q;
  end

  assign sdram_dout_o = dout_q;
  assign sdram_ack_o  = ack_q;
  assign sdram_busy_o = busy_q;
  assign proto_err_o  = perr_q;

endmodule
